// File: rtl/aclock_pkg.sv
// Shared types and constants for the aclock user-interface controller.
package aclock_pkg;

  typedef enum logic [2:0] {
    E_IDLE,
    E_EDIT_T,
    E_EDIT_A,
    E_COMMIT_T,
    E_COMMIT_A
  } edit_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_RING,
    A_SNOOZE,
    A_MUTE
  } alarm_state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } digits_t;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_H2 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_TIME  = 2'd1;
  localparam logic [1:0] MODE_ALARM = 2'd2;

  // Counters load N-1 and expire at zero, so $clog2(N) bits are enough.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/aclock_ctrl_digit_editor.sv
// Edit digit register and cursor: seeding, cursor advance, increment with wrap and H0 clamp.
module digit_editor
  import aclock_pkg::*;
(
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       i_seed,
  input  digits_t    i_seed_val,
  input  logic       i_inc,
  input  logic       i_next,
  input  logic       i_clr,
  output digits_t    o_digits,
  output logic [1:0] o_cursor
);

  digits_t    r_dig;
  digits_t    w_dig_inc;
  logic [1:0] r_cursor;
  logic [3:0] w_h0_lim;

  always_comb begin
    w_dig_inc = r_dig;
    w_h0_lim  = (r_dig.h1 == H1_MAX) ? H0_MAX_H2 : H0_MAX;
    case (r_cursor)
      2'd0: begin
        w_dig_inc.h1 = (r_dig.h1 >= H1_MAX) ? 2'd0 : r_dig.h1 + 2'd1;
        // Entering the 20s must not leave an hour above 23.
        if (w_dig_inc.h1 == H1_MAX && r_dig.h0 > H0_MAX_H2) w_dig_inc.h0 = 4'd0;
      end
      2'd1:    w_dig_inc.h0 = (r_dig.h0 >= w_h0_lim) ? 4'd0 : r_dig.h0 + 4'd1;
      2'd2:    w_dig_inc.m1 = (r_dig.m1 >= M1_MAX) ? 4'd0 : r_dig.m1 + 4'd1;
      default: w_dig_inc.m0 = (r_dig.m0 >= M0_MAX) ? 4'd0 : r_dig.m0 + 4'd1;
    endcase
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_dig    <= '0;
      r_cursor <= 2'd0;
    end else if (i_seed) begin
      r_dig    <= i_seed_val;
      r_cursor <= 2'd0;
    end else if (i_clr) begin
      r_cursor <= 2'd0;
    end else if (i_next) begin
      r_cursor <= r_cursor + 2'd1;
    end else if (i_inc) begin
      r_dig    <= w_dig_inc;
    end
  end

  assign o_digits = r_dig;
  assign o_cursor = r_cursor;

endmodule

// File: rtl/aclock_ctrl.sv
// Button-driven time/alarm editing plus ring, snooze and dismiss sequencing for aclock.
module aclock_ctrl
  import aclock_pkg::*;
#(
  parameter int unsigned SNOOZE_S   = 300,
  parameter int unsigned RING_S     = 60,
  parameter int unsigned MUTE_S     = 60,
  parameter int unsigned EDIT_TO    = 30,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       reset,
  input  logic       clk_1s,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_alon,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       Alarm,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       STOP_al,
  output logic       buzzer,
  output logic [1:0] edit_mode,
  output logic [1:0] edit_digit
);

  localparam int unsigned AL_MAX = (SNOOZE_S > RING_S) ?
                                   ((SNOOZE_S > MUTE_S) ? SNOOZE_S : MUTE_S) :
                                   ((RING_S > MUTE_S) ? RING_S : MUTE_S);
  localparam int unsigned ET_W = cnt_w(EDIT_TO);
  localparam int unsigned AL_W = cnt_w(AL_MAX);
  localparam int unsigned SN_W = cnt_w(MAX_SNOOZE + 1);

  localparam logic [ET_W-1:0] ET_LOAD   = ET_W'(EDIT_TO - 1);
  localparam logic [AL_W-1:0] RING_LOAD = AL_W'(RING_S - 1);
  localparam logic [AL_W-1:0] SNZ_LOAD  = AL_W'(SNOOZE_S - 1);
  localparam logic [AL_W-1:0] MUTE_LOAD = AL_W'(MUTE_S - 1);
  localparam logic [SN_W-1:0] SNZ_MAX   = SN_W'(MAX_SNOOZE);

  logic [5:0]   w_btn, w_edge, r_btn_prev;
  logic         w_e_mode, w_e_next, w_e_inc, w_e_alon, w_e_stop, w_e_snooze;

  edit_state_t  r_edit_state, w_edit_nxt;
  logic [ET_W-1:0] r_to_cnt, w_to_nxt;
  logic         w_seed, w_inc, w_next, w_clr;
  digits_t      w_seed_val, w_cur, w_dig, r_shadow;
  logic [1:0]   w_cursor, w_mode_nxt;
  logic         r_ld_time, r_ld_alarm, r_al_on, w_al_on_nxt;
  logic [1:0]   r_edit_mode;

  alarm_state_t r_al_state, w_al_nxt;
  logic [AL_W-1:0] r_al_cnt, w_al_cnt_nxt;
  logic [SN_W-1:0] r_snz_cnt, w_snz_nxt;
  logic         w_go_mute, r_buzzer, r_stop_al;

  assign w_btn      = {btn_snooze, btn_stop, btn_alon, btn_inc, btn_next, btn_mode};
  assign w_edge     = w_btn & ~r_btn_prev;
  assign w_e_mode   = w_edge[0];
  assign w_e_next   = w_edge[1];
  assign w_e_inc    = w_edge[2];
  assign w_e_alon   = w_edge[3];
  assign w_e_stop   = w_edge[4];
  assign w_e_snooze = w_edge[5];
  assign w_cur      = '{h1: cur_h1, h0: cur_h0, m1: cur_m1, m0: cur_m0};

  always_comb begin
    w_edit_nxt = r_edit_state;
    w_to_nxt   = r_to_cnt;
    w_seed     = 1'b0;
    w_seed_val = w_cur;
    w_inc      = 1'b0;
    w_next     = 1'b0;
    w_clr      = 1'b0;
    case (r_edit_state)
      E_IDLE: begin
        if (w_e_mode) begin
          w_edit_nxt = E_EDIT_T;
          w_seed     = 1'b1;
          w_to_nxt   = ET_LOAD;
        end
      end
      E_EDIT_T, E_EDIT_A: begin
        if (w_e_mode || w_e_next || w_e_inc) w_to_nxt = ET_LOAD;
        else if (r_to_cnt != '0)            w_to_nxt = r_to_cnt - 1'b1;
        if (w_e_mode) begin
          if (r_edit_state == E_EDIT_T) begin
            w_edit_nxt = E_EDIT_A;
            w_seed     = 1'b1;
            w_seed_val = r_shadow;
          end else begin
            w_edit_nxt = E_IDLE;
            w_clr      = 1'b1;
          end
        end else if (w_e_next) begin
          w_next = 1'b1;
          if (w_cursor == 2'd3)
            w_edit_nxt = (r_edit_state == E_EDIT_T) ? E_COMMIT_T : E_COMMIT_A;
        end else if (w_e_inc) begin
          w_inc = 1'b1;
        end else if (r_to_cnt == '0) begin
          w_edit_nxt = E_IDLE;
          w_clr      = 1'b1;
        end
      end
      default: w_edit_nxt = E_IDLE;
    endcase
  end

  always_comb begin
    case (w_edit_nxt)
      E_EDIT_T, E_COMMIT_T: w_mode_nxt = MODE_TIME;
      E_EDIT_A, E_COMMIT_A: w_mode_nxt = MODE_ALARM;
      default:              w_mode_nxt = MODE_IDLE;
    endcase
  end

  // While ringing or snoozed the alarm-enable button can only switch the alarm off.
  always_comb begin
    w_al_on_nxt = r_al_on;
    if (w_e_alon) begin
      if (r_al_state == A_RING || r_al_state == A_SNOOZE) w_al_on_nxt = 1'b0;
      else if (r_edit_state == E_IDLE)                    w_al_on_nxt = ~r_al_on;
    end
  end

  digit_editor u_digit_editor (
    .clk_1s     (clk_1s),
    .reset      (reset),
    .i_seed     (w_seed),
    .i_seed_val (w_seed_val),
    .i_inc      (w_inc),
    .i_next     (w_next),
    .i_clr      (w_clr),
    .o_digits   (w_dig),
    .o_cursor   (w_cursor)
  );

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_btn_prev   <= '0;
      r_edit_state <= E_IDLE;
      r_to_cnt     <= '0;
      r_ld_time    <= 1'b0;
      r_ld_alarm   <= 1'b0;
      r_edit_mode  <= MODE_IDLE;
      r_shadow     <= '0;
      r_al_on      <= 1'b0;
    end else begin
      r_btn_prev   <= w_btn;
      r_edit_state <= w_edit_nxt;
      r_to_cnt     <= w_to_nxt;
      r_ld_time    <= (w_edit_nxt == E_COMMIT_T);
      r_ld_alarm   <= (w_edit_nxt == E_COMMIT_A);
      r_edit_mode  <= w_mode_nxt;
      r_al_on      <= w_al_on_nxt;
      if (w_edit_nxt == E_COMMIT_A) r_shadow <= w_dig;
    end
  end

  always_comb begin
    w_al_nxt     = r_al_state;
    w_al_cnt_nxt = r_al_cnt;
    w_snz_nxt    = r_snz_cnt;
    w_go_mute    = 1'b0;
    case (r_al_state)
      A_IDLE: begin
        if (Alarm && w_al_on_nxt) begin
          w_al_nxt     = A_RING;
          w_al_cnt_nxt = RING_LOAD;
          w_snz_nxt    = '0;
        end
      end
      A_RING: begin
        if (!w_al_on_nxt || w_e_stop) begin
          w_go_mute = 1'b1;
        end else if (w_e_snooze) begin
          if (r_snz_cnt < SNZ_MAX) begin
            w_al_nxt     = A_SNOOZE;
            w_al_cnt_nxt = SNZ_LOAD;
          end else begin
            w_go_mute = 1'b1;
          end
        end else if (r_al_cnt == '0) begin
          w_go_mute = 1'b1;
        end else begin
          w_al_cnt_nxt = r_al_cnt - 1'b1;
        end
      end
      A_SNOOZE: begin
        if (!w_al_on_nxt || w_e_stop) begin
          w_go_mute = 1'b1;
        end else if (r_al_cnt == '0) begin
          w_al_nxt     = A_RING;
          w_al_cnt_nxt = RING_LOAD;
          w_snz_nxt    = r_snz_cnt + SN_W'(1);
        end else begin
          w_al_cnt_nxt = r_al_cnt - 1'b1;
        end
      end
      default: begin
        if (r_al_cnt == '0) w_al_nxt = A_IDLE;
        else                w_al_cnt_nxt = r_al_cnt - 1'b1;
      end
    endcase
    if (w_go_mute) begin
      w_al_nxt     = A_MUTE;
      w_al_cnt_nxt = MUTE_LOAD;
    end
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_al_state <= A_IDLE;
      r_al_cnt   <= '0;
      r_snz_cnt  <= '0;
      r_buzzer   <= 1'b0;
      r_stop_al  <= 1'b0;
    end else begin
      r_al_state <= w_al_nxt;
      r_al_cnt   <= w_al_cnt_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_buzzer   <= (w_al_nxt == A_RING);
      r_stop_al  <= (w_al_nxt == A_SNOOZE) || (w_al_nxt == A_MUTE);
    end
  end

  assign H_in1      = w_dig.h1;
  assign H_in0      = w_dig.h0;
  assign M_in1      = w_dig.m1;
  assign M_in0      = w_dig.m0;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign AL_ON      = r_al_on;
  assign STOP_al    = r_stop_al;
  assign buzzer     = r_buzzer;
  assign edit_mode  = r_edit_mode;
  assign edit_digit = w_cursor;

endmodule

// File: tb/tb_aclock_ctrl.sv
// Directed and randomized bench for aclock_ctrl against a behavioural model of the UI rules.
module tb_aclock_ctrl;

  localparam int SNOOZE_S   = 300;
  localparam int RING_S     = 60;
  localparam int MUTE_S     = 60;
  localparam int EDIT_TO    = 30;
  localparam int MAX_SNOOZE = 3;

  logic       clk_1s = 1'b0;
  logic       reset  = 1'b0;
  logic [5:0] btn    = '0;   // mode, next, inc, alon, stop, snooze
  logic       Alarm  = 1'b0;
  logic [1:0] cur_h1 = '0;
  logic [3:0] cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, AL_ON, STOP_al, buzzer;
  logic [1:0] edit_mode, edit_digit;

  aclock_ctrl #(
    .SNOOZE_S(SNOOZE_S), .RING_S(RING_S), .MUTE_S(MUTE_S),
    .EDIT_TO(EDIT_TO), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .reset(reset), .clk_1s(clk_1s),
    .btn_mode(btn[0]), .btn_next(btn[1]), .btn_inc(btn[2]),
    .btn_alon(btn[3]), .btn_stop(btn[4]), .btn_snooze(btn[5]),
    .Alarm(Alarm),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al),
    .buzzer(buzzer), .edit_mode(edit_mode), .edit_digit(edit_digit)
  );

  always #5 clk_1s = ~clk_1s;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: edit mode 0/1/2, a pending-commit flag, digits as plain ints,
  // alarm phase 0 off / 1 ring / 2 snooze / 3 mute with elapsed-cycle count.
  int   m_emode, m_cur, m_idle, m_ph, m_t, m_sn;
  int   m_dig[4];
  int   m_shadow[4];
  bit   m_commit, m_ldt, m_lda, m_alon;
  logic [5:0] m_prev;

  function automatic logic [31:0] bus_val();
    return 32'({H_in1, H_in0, M_in1, M_in0});
  endfunction

  task automatic model_reset();
    m_emode = 0; m_cur = 0; m_idle = 0; m_ph = 0; m_t = 0; m_sn = 0;
    m_commit = 0; m_ldt = 0; m_lda = 0; m_alon = 0; m_prev = '0;
    for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_shadow[i] = 0; end
  endtask

  task automatic go_phase(input int p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic model_step();
    logic [5:0] e;
    bit was_idle, active;
    int lim;
    e        = btn & ~m_prev;
    m_prev   = btn;
    was_idle = (m_emode == 0) && !m_commit;
    active   = (m_ph == 1) || (m_ph == 2);
    if (e[3]) begin
      if (active)        m_alon = 0;
      else if (was_idle) m_alon = !m_alon;
    end
    m_ldt = 0;
    m_lda = 0;
    if (m_commit) begin
      m_commit = 0;
      m_emode  = 0;
    end else if (m_emode == 0) begin
      if (e[0]) begin
        m_emode = 1; m_cur = 0; m_idle = 0;
        m_dig[0] = cur_h1; m_dig[1] = cur_h0; m_dig[2] = cur_m1; m_dig[3] = cur_m0;
      end
    end else if (e[0]) begin
      m_idle = 0; m_cur = 0;
      if (m_emode == 1) begin
        m_emode = 2;
        for (int i = 0; i < 4; i++) m_dig[i] = m_shadow[i];
      end else m_emode = 0;
    end else if (e[1]) begin
      m_idle = 0;
      if (m_cur == 3) begin
        m_cur = 0; m_commit = 1;
        if (m_emode == 1) m_ldt = 1;
        else begin
          m_lda = 1;
          for (int i = 0; i < 4; i++) m_shadow[i] = m_dig[i];
        end
      end else m_cur++;
    end else if (e[2]) begin
      m_idle = 0;
      case (m_cur)
        0: begin
          m_dig[0] = (m_dig[0] + 1) % 3;
          if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 0;
        end
        1: begin
          lim = (m_dig[0] == 2) ? 4 : 10;
          m_dig[1] = (m_dig[1] + 1) % lim;
        end
        2: m_dig[2] = (m_dig[2] + 1) % 6;
        default: m_dig[3] = (m_dig[3] + 1) % 10;
      endcase
    end else begin
      m_idle++;
      if (m_idle == EDIT_TO) begin m_emode = 0; m_cur = 0; end
    end
    case (m_ph)
      0: if (Alarm && m_alon) begin go_phase(1); m_sn = 0; end
      1: begin
        if (!m_alon || e[4]) go_phase(3);
        else if (e[5]) go_phase((m_sn < MAX_SNOOZE) ? 2 : 3);
        else begin m_t++; if (m_t == RING_S) go_phase(3); end
      end
      2: begin
        if (!m_alon || e[4]) go_phase(3);
        else begin
          m_t++;
          if (m_t == SNOOZE_S) begin go_phase(1); m_sn++; end
        end
      end
      default: begin m_t++; if (m_t == MUTE_S) go_phase(0); end
    endcase
  endtask

  task automatic compare_all();
    chk("ld_time",    32'(LD_time),    32'(m_ldt));
    chk("ld_alarm",   32'(LD_alarm),   32'(m_lda));
    chk("al_on",      32'(AL_ON),      32'(m_alon));
    chk("buzzer",     32'(buzzer),     32'(m_ph == 1));
    chk("stop_al",    32'(STOP_al),    32'(m_ph == 2 || m_ph == 3));
    chk("edit_mode",  32'(edit_mode),  32'(m_emode));
    chk("edit_digit", 32'(edit_digit), 32'(m_cur));
    chk("bus", bus_val(), 32'((m_dig[0] << 12) | (m_dig[1] << 8) | (m_dig[2] << 4) | m_dig[3]));
  endtask

  task automatic cyc();
    @(posedge clk_1s);
    model_step();
    @(negedge clk_1s);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1; cyc();
    btn[b] = 1'b0; cyc();
  endtask

  task automatic press_n(input int b, input int n);
    repeat (n) press(b);
  endtask

  task automatic pulse_alarm();
    Alarm = 1'b1; cyc();
    Alarm = 1'b0;
    chk("alarm_to_buzzer", 32'(buzzer), 32'd1);
  endtask

  // Asserted away from the clock edge; outputs must clear without waiting for one.
  task automatic apply_reset();
    #2;
    btn = '0; Alarm = 1'b0; reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk_1s);
    @(negedge clk_1s);
    reset = 1'b0;
  endtask

  task automatic rand_cur();
    cur_h1 = 2'($urandom_range(2));
    cur_h0 = 4'((cur_h1 == 2'd2) ? $urandom_range(3) : $urandom_range(9));
    cur_m1 = 4'($urandom_range(5));
    cur_m0 = 4'($urandom_range(9));
  endtask

  initial begin
    int seq[4];
    seq = '{1, 2, 3, 0};
    #1;
    apply_reset();

    // Set time to 13:45 from 00:00.
    press(0);
    press_n(2, 1); press(1);
    press_n(2, 3); press(1);
    press_n(2, 4); press(1);
    press_n(2, 5);
    btn[1] = 1'b1; cyc();
    chk("set_ld_time", 32'(LD_time), 32'd1);
    chk("set_bus", bus_val(), 32'h1345);
    btn[1] = 1'b0; cyc();
    chk("set_ld_once", 32'(LD_time), 32'd0);
    chk("set_mode_idle", 32'(edit_mode), 32'd0);

    // Clamp: 19:00 -> 20:00, then H0 wraps at 3.
    cur_h1 = 2'd1; cur_h0 = 4'd9; cur_m1 = 4'd0; cur_m0 = 4'd0;
    press(0);
    press(2);
    chk("clamp_bus", bus_val(), 32'h2000);
    press(1);
    for (int k = 0; k < 4; k++) begin
      press(2);
      chk("clamp_h0", 32'(H_in0), 32'(seq[k]));
    end
    press(0); press(0);

    // Commit alarm 07:30, then an aborted alarm edit leaves it unchanged.
    press(0); press(0);
    press(1); press_n(2, 7);
    press(1); press_n(2, 3);
    press(1);
    btn[1] = 1'b1; cyc();
    chk("alarm_ld", 32'(LD_alarm), 32'd1);
    chk("alarm_bus", bus_val(), 32'h0730);
    btn[1] = 1'b0; cyc();
    press(0); press(0);
    chk("shadow_seed", bus_val(), 32'h0730);
    press(2); press(1); press(2);
    press(0);
    chk("abort_idle", 32'(edit_mode), 32'd0);
    press(0); press(0);
    chk("shadow_kept", bus_val(), 32'h0730);
    press(0);

    // Edit timeout after EDIT_TO quiet cycles.
    press(0);
    idle(EDIT_TO - 2);
    chk("timeout_before", 32'(edit_mode), 32'd1);
    cyc();
    chk("timeout_after", 32'(edit_mode), 32'd0);

    // Snooze three times, the fourth press mutes.
    press(3);
    chk("al_on_set", 32'(AL_ON), 32'd1);
    pulse_alarm();
    for (int s = 0; s < MAX_SNOOZE; s++) begin
      btn[5] = 1'b1; cyc(); btn[5] = 1'b0;
      chk("snooze_stop", 32'(STOP_al), 32'd1);
      chk("snooze_quiet", 32'(buzzer), 32'd0);
      idle(SNOOZE_S - 1);
      chk("snooze_still_quiet", 32'(buzzer), 32'd0);
      cyc();
      chk("rering", 32'(buzzer), 32'd1);
    end
    btn[5] = 1'b1; cyc(); btn[5] = 1'b0;
    chk("last_snooze_mute", 32'(STOP_al), 32'd1);
    idle(MUTE_S - 1);
    chk("mute_held", 32'(STOP_al), 32'd1);
    cyc();
    chk("mute_end", 32'(STOP_al), 32'd0);
    chk("mute_no_ring", 32'(buzzer), 32'd0);

    // Auto dismiss after RING_S.
    pulse_alarm();
    idle(RING_S - 1);
    chk("ring_held", 32'(buzzer), 32'd1);
    cyc();
    chk("auto_dismiss", 32'(buzzer), 32'd0);
    chk("auto_mute", 32'(STOP_al), 32'd1);
    idle(MUTE_S - 1);
    chk("auto_mute_held", 32'(STOP_al), 32'd1);
    cyc();
    chk("auto_mute_end", 32'(STOP_al), 32'd0);

    // Stop and snooze together: stop wins, mute lasts MUTE_S only.
    pulse_alarm();
    btn[4] = 1'b1; btn[5] = 1'b1; cyc();
    btn[4] = 1'b0; btn[5] = 1'b0;
    chk("both_mute", 32'(STOP_al), 32'd1);
    idle(MUTE_S - 1);
    cyc();
    chk("both_not_snooze", 32'(STOP_al), 32'd0);

    // Clearing AL_ON while ringing forces mute.
    pulse_alarm();
    press(3);
    chk("alon_clear", 32'(AL_ON), 32'd0);
    chk("alon_mute", 32'(STOP_al), 32'd1);
    idle(MUTE_S);

    // Reset during RING and EDIT_A.
    press(3);
    pulse_alarm();
    press(0); press(0); press(2);
    btn[1] = 1'b1;
    apply_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++) btn[b] = ($urandom_range(7) == 0);
      Alarm = ($urandom_range(40) == 0);
      if ($urandom_range(15) == 0) rand_cur();
      cyc();
      if (i % 1000 == 999) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aclock_ctrl.md
# aclock_ctrl

User-interface and alarm-sequencing controller for the `aclock` timekeeper. It turns debounced push-buttons into digit-by-digit editing of clock time and alarm time, and drives the `LD_time` / `LD_alarm` / digit bus / `AL_ON` inputs of `aclock`. It also runs the ringing, snooze and dismiss sequence on top of the raw `Alarm` flag, producing `STOP_al` and the user-facing `buzzer`.

## Interface
- `SNOOZE_S`, default 300: seconds of silence after a snooze before re-ringing.
- `RING_S`, default 60: seconds of unattended ringing before auto-dismiss.
- `MUTE_S`, default 60: seconds `STOP_al` is held after dismiss; covers the rest of the matching minute.
- `EDIT_TO`, default 30: seconds without a button press before an edit aborts.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; the next snooze is treated as a stop.
- `reset` input 1: reset, asynchronous, active-high.
- `clk_1s` input 1: clock (the 1 Hz tick from `aclock`).
- `btn_mode`, `btn_next`, `btn_inc`, `btn_alon`, `btn_stop`, `btn_snooze` input 1 each: debounced level buttons.
- `Alarm` input 1: alarm flag from `aclock`.
- `cur_h1` input 2, `cur_h0` / `cur_m1` / `cur_m0` input 4 each: current displayed time digits.
- `H_in1` output 2, `H_in0` / `M_in1` / `M_in0` output 4 each: edit digit bus to `aclock`.
- `LD_time`, `LD_alarm` output 1 each: one-cycle load strobes.
- `AL_ON` output 1: alarm enable level.
- `STOP_al` output 1: alarm clear level.
- `buzzer` output 1: audible alarm.
- `edit_mode` output 2: 0 = idle, 1 = editing time, 2 = editing alarm.
- `edit_digit` output 2: cursor position, 0 = H1, 1 = H0, 2 = M1, 3 = M0.

## Operation
- **Button handling:** each button is edge-detected in-block as a rising edge against the previous-cycle sample. Priority within the edit FSM: mode > next > inc. `btn_stop` beats `btn_snooze`.
- **Edit FSM states:**
  - IDLE
    - `btn_mode` → EDIT_T, with the edit digits seeded from `cur_*`.
    - `btn_alon` toggles `AL_ON`.
  - EDIT_T
    - `btn_mode` → EDIT_A, with the edit digits seeded from the alarm shadow register.
  - EDIT_A
    - `btn_mode` → IDLE; this aborts with no load.
  - EDIT_T and EDIT_A, common rules:
    - `btn_inc` increments the digit under the cursor.
    - `btn_next` advances the cursor.
    - `btn_next` at cursor 3 → COMMIT_T or COMMIT_A, with the cursor reset to 0.
  - COMMIT_T: `LD_time` = 1 for exactly one cycle, then → IDLE.
  - COMMIT_A: `LD_alarm` = 1 for exactly one cycle; the shadow register is updated; then → IDLE.
  - Edit timeout: `EDIT_TO` cycles with no edge on any edit button → IDLE, no load.
- **Digit legality on increment:**
  - H1 wraps 0→1→2→0.
  - H0 wraps 9→0, except when H1 = 2, where it wraps 3→0.
  - M1 wraps 5→0.
  - M0 wraps 9→0.
  - When H1 becomes 2 while H0 > 3, H0 is cleared to 0 in the same cycle.
- **Digit bus:** in IDLE the bus holds its last value. The bus is stable during, and for the cycle before, any load strobe.
- **Alarm FSM states:**
  - A_IDLE: `Alarm` = 1 → RING; the snooze count is cleared.
  - RING: `buzzer` = 1.
    - `btn_stop`, or `RING_S` elapsed → MUTE.
    - `btn_snooze` → SNOOZE if snooze count < `MAX_SNOOZE`, otherwise → MUTE.
  - SNOOZE: `STOP_al` = 1, `buzzer` = 0; counts `SNOOZE_S`, then → RING with snooze count + 1.
  - MUTE: `STOP_al` = 1; counts `MUTE_S`, then → A_IDLE.
  - `btn_stop` in SNOOZE → MUTE.
- **AL_ON interaction:** `AL_ON` toggled to 0 in any alarm state forces → MUTE. In that state `btn_alon` acts as a toggle in IDLE only, and as an `AL_ON` clear anywhere.
- **Independence:** the edit and alarm FSMs run in parallel. Committing a new alarm time does not disturb an ongoing RING or SNOOZE.
- **Counter width:** one shared down-counter per FSM, sized `$clog2` of the largest parameter it serves.

## Timing
- Everything is registered on `clk_1s`; all outputs are registered.
- Button edge → FSM action on the same edge the edge is detected, i.e. one cycle after the button level rises.
- COMMIT strobe → the `aclock` load takes effect on the next `clk_1s`.
- `Alarm` rise → `buzzer` = 1 one cycle later.
- `btn_snooze` edge → `STOP_al` = 1 the next cycle.
- Re-ring occurs exactly `SNOOZE_S` cycles after entering SNOOZE.
- `STOP_al` is held for exactly `MUTE_S` cycles.
- Reset values:
  - Both FSMs idle.
  - All outputs 0.
  - Shadow register 00:00.
  - Digits 00:00.
  - Counters and snooze count 0.
- Reset mid-edit or mid-ring discards everything; no strobe is emitted.

## Structure
- Shared package `aclock_pkg` holds:
  - the edit and alarm state enums;
  - the digit-limit constants (2, 9, 3, 5);
  - the `edit_mode` encodings.
- One natural sub-module, `digit_editor`, handles cursor, increment/wrap/clamp and seeding. The alarm FSM lives in the top module.

## Test plan
- **Set time:** mode, then inc×1 on H1, next, inc×3, next, inc×4, next, inc×5, next → one-cycle `LD_time` with bus 13:45; `edit_mode` returns to 0.
- **Clamp:** seed 19:00, H1 inc → bus 20:00. Then H0 inc×4 → H0 sequence 1, 2, 3, 0.
- **Alarm edit and abort:** mode, mode, edits, mode → no strobe, shadow unchanged. Separately, no button for 30 cycles in EDIT_T → back to idle, no strobe.
- **Snooze:** pulse `Alarm` with `AL_ON` = 1 → `buzzer` next cycle; snooze → `STOP_al` = 1 for 300 cycles; `buzzer` reasserts on cycle 300. The 4th snooze → MUTE for 60 cycles.
- **Auto dismiss:** ring for 60 cycles with no buttons → `buzzer` drops and `STOP_al` = 1 for exactly 60 cycles. `btn_stop` and `btn_snooze` pressed together → MUTE.
- **Reset mid-operation:** reset during RING and EDIT_A → all outputs 0 immediately, `buzzer` = 0, no `LD_alarm` strobe.
